// File: rtl/pixel_sink.sv
// pixel_sink
//   Stores pixels written on a 160x120 logical grid in a 19200x12 framebuffer
//   and scans them out as upscaled 640x480 VGA video (800x525 total timing,
//   25 MHz pixel clock). The write port and the scan read port are
//   independent; the read returns old data when both hit the same address on
//   the same edge.
//
// Parameters
//   SCALE_SHIFT  log2 of the logical-to-output upscale factor
//   BLANK_COLOR  RGB driven while blank is high
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous reset, active HIGH despite its name
//   CounterX/Y   pixel write column / row (logical grid)
//   color        write data {R,G,B} 4 bits each
//   pixel_we     write strobe, one write per high cycle
//   vga_hs/vs    active-low syncs
//   vga_r/g/b    colour outputs
//   blank        high outside the 640x480 active area
//   frame_start  one-cycle pulse aligned with output pixel (0,0)
//   clip_count   number of discarded (out-of-range) writes
//
// Build option
//   CLIP_COUNT_EN  when defined, clip_count is a saturating counter;
//                  otherwise it is tied to zero.

module pixel_sink #(
  parameter int unsigned SCALE_SHIFT = 2,
  parameter logic [11:0] BLANK_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  CounterX,
  input  logic [7:0]  CounterY,
  input  logic [11:0] color,
  input  logic        pixel_we,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] clip_count
);

  localparam logic [9:0]  H_ACTIVE  = 10'd640;
  localparam logic [9:0]  H_SYNC_S  = 10'd656;
  localparam logic [9:0]  H_SYNC_E  = 10'd751;
  localparam logic [9:0]  H_LAST    = 10'd799;
  localparam logic [9:0]  V_ACTIVE  = 10'd480;
  localparam logic [9:0]  V_SYNC_S  = 10'd490;
  localparam logic [9:0]  V_SYNC_E  = 10'd491;
  localparam logic [9:0]  V_LAST    = 10'd524;
  localparam logic [7:0]  LOG_W     = 8'd160;
  localparam logic [7:0]  LOG_H     = 8'd120;
  localparam logic [14:0] LOG_W15   = 15'd160;
  localparam int unsigned FB_DEPTH  = 19200;

  // ---------------------------------------------------------------- write side
  logic        w_in_range;
  logic [14:0] w_wr_addr;
  logic        r_wr_en;
  logic [14:0] r_wr_addr;
  logic [11:0] r_wr_data;
  logic [11:0] r_fb [0:FB_DEPTH-1];

  assign w_in_range = (CounterX < LOG_W) && (CounterY < LOG_H);
  assign w_wr_addr  = 15'(CounterY) * LOG_W15 + 15'(CounterX);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= pixel_we && w_in_range;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= color;
    end
  end

  // Framebuffer contents survive reset; only the strobe register is cleared.
  always_ff @(posedge clk) begin
    if (r_wr_en) r_fb[r_wr_addr] <= r_wr_data;
  end

  // ---------------------------------------------------------------- timing
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;

  always_comb begin
    w_h_next = r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (r_h_cnt == H_LAST) begin
      w_h_next = '0;
      w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // ---------------------------------------------------------------- scan read
  // The read address is built from the next counter values so that it is
  // registered in step with the counters; with the RAM data register and the
  // output register this gives a two-cycle latency from counter to pins,
  // matching the two-stage delay of the sync/blank/frame_start path.
  logic [9:0]  w_lx;
  logic [9:0]  w_ly;
  logic        w_next_active;
  logic [14:0] w_rd_addr;
  logic [14:0] r_rd_addr;
  logic [11:0] r_ram_q;

  assign w_lx          = w_h_next >> SCALE_SHIFT;
  assign w_ly          = w_v_next >> SCALE_SHIFT;
  assign w_next_active = (w_h_next < H_ACTIVE) && (w_v_next < V_ACTIVE);
  // Outside the active area the address is parked at 0 so it never leaves
  // the array; those pixels are blanked anyway.
  assign w_rd_addr     = w_next_active ? (15'(w_ly) * LOG_W15 + 15'(w_lx)) : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rd_addr <= '0;
      r_ram_q   <= '0;
    end else begin
      r_rd_addr <= w_rd_addr;
      r_ram_q   <= r_fb[r_rd_addr];
    end
  end

  // ---------------------------------------------------------------- sync path
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_blank_raw;
  logic w_fs_raw;

  assign w_hs_raw    = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt <= H_SYNC_E));
  assign w_vs_raw    = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt <= V_SYNC_E));
  assign w_blank_raw = (r_h_cnt >= H_ACTIVE) || (r_v_cnt >= V_ACTIVE);
  assign w_fs_raw    = (r_h_cnt == '0) && (r_v_cnt == '0);

  logic        r_d1_hs;
  logic        r_d1_vs;
  logic        r_d1_blank;
  logic        r_d1_fs;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_fs;
  logic [11:0] r_rgb;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_d1_hs    <= 1'b1;
      r_d1_vs    <= 1'b1;
      r_d1_blank <= 1'b1;
      r_d1_fs    <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_blank    <= 1'b1;
      r_fs       <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_d1_hs    <= w_hs_raw;
      r_d1_vs    <= w_vs_raw;
      r_d1_blank <= w_blank_raw;
      r_d1_fs    <= w_fs_raw;
      r_hs       <= r_d1_hs;
      r_vs       <= r_d1_vs;
      r_blank    <= r_d1_blank;
      r_fs       <= r_d1_fs;
      r_rgb      <= r_d1_blank ? BLANK_COLOR : r_ram_q;
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_fs;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];

  // ---------------------------------------------------------------- clip count
`ifdef CLIP_COUNT_EN
  logic [15:0] r_clip_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_clip_cnt <= '0;
    end else if (pixel_we && !w_in_range && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  assign clip_count = r_clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule
